// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of SRAM_Controller: port 0 = MEM/cache miss, port 1 = IF fetch.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_en,
  input  logic              p0_wr_en,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_rd_en,
  input  logic              p1_wr_en,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic              rr_last_q, rr_last_d;
`endif

  logic req0, req1, gnt;
  logic sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req0 = p0_rd_en | p0_wr_en;
  assign req1 = p1_rd_en | p1_wr_en;

  always_comb begin
    gnt = req1 & ~req0;
    if (req0 && req1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      gnt = ~rr_last_q;
`else
      gnt = 1'b0;
`endif
    end
  end

  assign sel_rd    = gnt ? p1_rd_en : p0_rd_en;
  assign sel_wr    = gnt ? p1_wr_en : p0_wr_en;
  assign sel_addr  = gnt ? p1_addr  : p0_addr;
  assign sel_wdata = gnt ? p1_wdata : p0_wdata;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      S_IDLE: if (req0 || req1) begin
        owner_d = gnt;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        // rd+wr together is a write
        wr_d    = sel_wr;
        rd_d    = sel_rd & ~sel_wr;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_last_d = gnt;
`endif
        state_d = S_BUSY;
      end
      S_BUSY: if (sram_ready) begin
        if (rd_q) begin
          if (owner_q) rdata1_d = sram_rdata;
          else         rdata0_d = sram_rdata;
        end
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign p0_ready   = ~req0 | (state_q == S_RESP && owner_q == 1'b0);
  assign p1_ready   = ~req1 | (state_q == S_RESP && owner_q == 1'b1);
  assign p0_rdata   = rdata0_q;
  assign p1_rdata   = rdata1_q;
  assign sram_rd_en = rd_q;
  assign sram_wr_en = wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a fixed-latency SRAM responder (5 cycles to ready).
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic        sram_rd_en, sram_wr_en, sram_ready;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  // SRAM responder: ready pulses once, 5 edges after the enables rise
  logic [31:0] mem [int];
  int          lat_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_ready <= 1'b0;
      sram_rdata <= 32'h0;
      lat_cnt    <= 0;
    end else if (sram_ready) begin
      sram_ready <= 1'b0;
      lat_cnt    <= 0;
    end else if (sram_rd_en || sram_wr_en) begin
      if (lat_cnt == 4) begin
        sram_ready <= 1'b1;
        sram_rdata <= mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 32'h0;
        if (sram_wr_en) mem[int'(sram_addr)] = sram_wdata;
      end else lat_cnt <= lat_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits for the port's ready pulse while its request is held; returns cycles waited
  task automatic wait_rdy(input bit port, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if ((port ? p1_ready : p0_ready) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    n_cmp++;
    if (cyc == 0) begin
      n_err++;
      $display("FAIL wait_rdy_p%0d observed=timeout expected=ready", port);
    end
  endtask

  int cyc;

  initial begin
    mem[32'h400] = 32'hDEADBEEF;
    mem[32'h500] = 32'h11111111;
    mem[32'h600] = 32'h22222222;
    rst = 1'b1;
    {p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en} = '0;
    p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
    tick(); tick();
    chk("rst_rd_en", {31'b0, sram_rd_en}, 32'd0);
    chk("rst_wr_en", {31'b0, sram_wr_en}, 32'd0);
    chk("rst_addr", sram_addr, 32'h0);
    chk("rst_p0_ready", {31'b0, p0_ready}, 32'd1);
    chk("rst_p1_ready", {31'b0, p1_ready}, 32'd1);
    chk("rst_p1_rdata", p1_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // single read on port 1
    p1_rd_en = 1'b1; p1_addr = 32'h400;
    #1 chk("rd_p1_ready_req", {31'b0, p1_ready}, 32'd0);
    tick();
    chk("rd_sram_rd_en", {31'b0, sram_rd_en}, 32'd1);
    chk("rd_sram_addr", sram_addr, 32'h400);
    wait_rdy(1'b1, cyc);
    chk("rd_latency", cyc, 32'd6);
    chk("rd_p1_rdata", p1_rdata, 32'hDEADBEEF);
    chk("rd_p0_rdata_untouched", p0_rdata, 32'h0);
    tick();
    chk("rd_p1_ready_once", {31'b0, p1_ready}, 32'd0);
    chk("rd_en_dropped", {31'b0, sram_rd_en}, 32'd0);
    p1_rd_en = 1'b0;
    tick();

    // single write on port 0
    p0_wr_en = 1'b1; p0_addr = 32'h408; p0_wdata = 32'h12345678;
    tick();
    p0_wdata = 32'hFFFFFFFF;  // latched copy must be used
    chk("wr_sram_wr_en", {31'b0, sram_wr_en}, 32'd1);
    chk("wr_sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
    chk("wr_sram_wdata", sram_wdata, 32'h12345678);
    tick(); tick(); tick();
    chk("wr_en_held", {31'b0, sram_wr_en}, 32'd1);
    wait_rdy(1'b0, cyc);
    chk("wr_p0_rdata_kept", p0_rdata, 32'h0);
    tick();
    chk("wr_p0_ready_once", {31'b0, p0_ready}, 32'd0);
    p0_wr_en = 1'b0;
    tick();
    p0_rd_en = 1'b1; p0_addr = 32'h408;
    wait_rdy(1'b0, cyc);
    chk("wr_readback", p0_rdata, 32'h12345678);
    p0_rd_en = 1'b0;
    tick();

    // contention, then a repeated tie
    for (int r = 0; r < 2; r++) begin
      p0_rd_en = 1'b1; p0_addr = 32'h500;
      p1_rd_en = 1'b1; p1_addr = 32'h600;
      tick();
      chk("tie_first_p0", sram_addr, 32'h500);
      wait_rdy(1'b0, cyc);
      chk("tie_p0_rdata", p0_rdata, 32'h11111111);
      chk("tie_p1_waiting", {31'b0, p1_ready}, 32'd0);
      p0_rd_en = 1'b0;
      tick();
      chk("tie_idle_gap", {31'b0, sram_rd_en}, 32'd0);
      tick();
      chk("tie_second_p1", sram_addr, 32'h600);
      wait_rdy(1'b1, cyc);
      chk("tie_p1_rdata", p1_rdata, 32'h22222222);
      chk("tie_p0_rdata_hold", p0_rdata, 32'h11111111);
      p1_rd_en = 1'b0;
      tick();
    end

    // rd+wr together on port 1 is a write
    p1_rd_en = 1'b1; p1_wr_en = 1'b1; p1_addr = 32'h40C; p1_wdata = 32'hA5A5A5A5;
    tick();
    chk("rdwr_rd_en_low", {31'b0, sram_rd_en}, 32'd0);
    chk("rdwr_wr_en", {31'b0, sram_wr_en}, 32'd1);
    wait_rdy(1'b1, cyc);
    chk("rdwr_rdata_kept", p1_rdata, 32'h22222222);
    p1_wr_en = 1'b0;
    tick();
    tick();
    wait_rdy(1'b1, cyc);
    chk("rdwr_readback", p1_rdata, 32'hA5A5A5A5);
    p1_rd_en = 1'b0;
    tick();

    // p0 requests continuously, p1 arrives mid-transaction
    p0_rd_en = 1'b1; p0_addr = 32'h500;
    tick();
    p1_rd_en = 1'b1; p1_addr = 32'h600;
    wait_rdy(1'b0, cyc);
    tick();
    tick();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    chk("starve_next_grant", sram_addr, 32'h600);
`else
    chk("starve_next_grant", sram_addr, 32'h500);
`endif

    // reset mid-BUSY
    tick();
    chk("busy_rd_en", {31'b0, sram_rd_en}, 32'd1);
    p0_rd_en = 1'b0; p1_rd_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", {31'b0, sram_rd_en}, 32'd0);
    chk("midrst_wr_en", {31'b0, sram_wr_en}, 32'd0);
    chk("midrst_p0_ready", {31'b0, p0_ready}, 32'd1);
    chk("midrst_p1_ready", {31'b0, p1_ready}, 32'd1);
    chk("midrst_p1_rdata", p1_rdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
